// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the fetch-stage run-control, redirect, instruction
// memory and IF/ID signals into one port.
//   master : the fetch stage (drives imem_en/imem_addr and the IF/ID outputs)
//   slave  : the surrounding pipeline / memory (drives tr, stall, redirect,
//            imem_rdata)
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            tr;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     fetch_count;

  modport master (
    input  tr, stall, redirect_valid, redirect_target, imem_rdata,
    output imem_en, imem_addr, id_valid, id_instr, id_pc, fetch_count
  );

  modport slave (
    output tr, stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_en, imem_addr, id_valid, id_instr, id_pc, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of a 5-stage RISC-V pipeline.
// Owns the PC, issues reads to a synchronous instruction memory with one
// cycle of read latency, and holds the IF/ID pipeline register.
// Ports:
//   clk             - system clock, rising edge
//   reset           - synchronous, active-high
//   initial_address - PC value loaded on reset
//   bus (master)    - tr / stall / redirect inputs, imem read port,
//                     IF/ID outputs (id_valid, id_instr, id_pc) and
//                     fetch_count (instructions delivered to ID)
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] initial_address,
  fetch_stage_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            pending_r;
  logic            id_valid_r;
  logic [XLEN-1:0] id_instr_r;
  logic [XLEN-1:0] id_pc_r;
  logic [31:0]     fetch_count_r;

  logic            issue_s;
  logic            deliver_s;
  logic [XLEN-1:0] redirect_pc_s;

  // Issue / deliver qualifiers; a redirect blocks both so the in-flight
  // read is dropped and no read goes out to the now-wrong PC.
  always_comb begin
    issue_s       = 1'b0;
    deliver_s     = 1'b0;
    redirect_pc_s = {XLEN{1'b0}};
    issue_s       = (state_r == RUN) & bus.tr & ~bus.stall & ~bus.redirect_valid;
    deliver_s     = pending_r & ~bus.stall & ~bus.redirect_valid;
    redirect_pc_s = bus.redirect_target & ~{{(XLEN-2){1'b0}}, 2'b11};
  end

  // Run-control FSM together with PC, in-flight tracking and IF/ID register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      pc_r          <= initial_address;
      req_pc_r      <= {XLEN{1'b0}};
      pending_r     <= 1'b0;
      id_valid_r    <= 1'b0;
      id_instr_r    <= NOP_INSTR;
      id_pc_r       <= {XLEN{1'b0}};
      fetch_count_r <= 32'd0;
    end else begin
      // DRAIN waits for the last in-flight read to reach ID before idling.
      case (state_r)
        IDLE: begin
          if (bus.tr) state_r <= RUN;
          else        state_r <= IDLE;
        end
        RUN: begin
          if (!bus.tr) state_r <= DRAIN;
          else         state_r <= RUN;
        end
        DRAIN: begin
          if (bus.tr)          state_r <= RUN;
          else if (!pending_r) state_r <= IDLE;
          else                 state_r <= DRAIN;
        end
        default: state_r <= IDLE;
      endcase

      // PC and in-flight bookkeeping. Issue and delivery can coincide, in
      // which case pending simply stays set for the newly issued read.
      if (bus.redirect_valid) begin
        pc_r      <= redirect_pc_s;
        pending_r <= 1'b0;
      end else if (issue_s) begin
        pc_r      <= pc_r + {{(XLEN-3){1'b0}}, 3'd4};
        req_pc_r  <= pc_r;
        pending_r <= 1'b1;
      end else if (deliver_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end

      // IF/ID register. While stalled the memory keeps the in-flight word on
      // imem_rdata, so it is picked up on the first edge after the stall.
      // A redirect in IDLE only moves the PC and leaves IF/ID untouched.
      if (bus.redirect_valid) begin
        if (state_r != IDLE) begin
          id_valid_r <= 1'b0;
          id_instr_r <= NOP_INSTR;
        end else begin
          id_valid_r <= id_valid_r;
        end
      end else if (bus.stall) begin
        id_valid_r <= id_valid_r;
      end else if (pending_r) begin
        id_valid_r    <= 1'b1;
        id_instr_r    <= bus.imem_rdata;
        id_pc_r       <= req_pc_r;
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        id_valid_r <= 1'b0;
        id_instr_r <= NOP_INSTR;
      end
    end
  end

  assign bus.imem_en     = issue_s;
  assign bus.imem_addr   = pc_r;
  assign bus.id_valid    = id_valid_r;
  assign bus.id_instr    = id_instr_r;
  assign bus.id_pc       = id_pc_r;
  assign bus.fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized + directed bench for fetch_stage. A transaction
// level model tracks the run mode, the in-flight read addresses and the
// expected delivery stream; deliveries are pushed to a scoreboard queue and a
// negedge monitor pops them whenever the DUT's fetch_count advances.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] initial_address;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(.XLEN(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .initial_address (initial_address),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA_0000 + a;
  endfunction

  // Synchronous instruction memory: 1-cycle latency, holds output when idle.
  always @(posedge clk) begin
    if (bus.imem_en === 1'b1) bus.imem_rdata <= mem_word(bus.imem_addr);
  end

  // ---------------- reference model ----------------
  int          m_mode = 0;          // 0 idle, 1 running, 2 draining
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_count = 32'd0;
  bit          m_valid = 1'b0;
  logic [31:0] inflight[$];
  logic [63:0] expq[$];
  bit          started = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit          en;
    bit          empty_before;
    int          mode_before;
    logic [31:0] a;
    if (reset) begin
      m_pc    = initial_address;
      m_mode  = 0;
      m_valid = 1'b0;
      m_count = 32'd0;
      inflight.delete();
      started = 1'b1;
      return;
    end
    if (!started) return;
    en           = (m_mode == 1) && bus.tr && !bus.stall && !bus.redirect_valid;
    empty_before = (inflight.size() == 0);
    mode_before  = m_mode;
    if (bus.redirect_valid) begin
      m_pc = bus.redirect_target & 32'hFFFF_FFFC;
      inflight.delete();
      if (mode_before != 0) m_valid = 1'b0;
    end else if (!bus.stall) begin
      if (!empty_before) begin
        a = inflight.pop_front();
        m_valid = 1'b1;
        m_count = m_count + 32'd1;
        expq.push_back({a, mem_word(a)});
      end else begin
        m_valid = 1'b0;
      end
    end
    if (en) begin
      inflight.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    case (mode_before)
      0: if (bus.tr) m_mode = 1;
      1: if (!bus.tr) m_mode = 2;
      2: if (bus.tr) m_mode = 1; else if (empty_before) m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] seen_count = 32'd0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (started) begin
      check("imem_en", {31'd0, bus.imem_en},
            {31'd0, (m_mode == 1) && bus.tr && !bus.stall && !bus.redirect_valid});
      check("imem_addr", bus.imem_addr, m_pc);
      check("id_valid", {31'd0, bus.id_valid}, {31'd0, m_valid});
      check("fetch_count", bus.fetch_count, m_count);
      if (bus.id_valid !== 1'b1) check("bubble_instr", bus.id_instr, NOP);
      if (bus.id_valid === 1'b1 && bus.fetch_count !== seen_count) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got pc %h, required no delivery", bus.id_pc);
        end else begin
          e = expq.pop_front();
          check("id_pc", bus.id_pc, e[63:32]);
          check("id_instr", bus.id_instr, e[31:0]);
        end
      end
      seen_count = bus.fetch_count;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rst, input bit t, input bit s, input bit rv,
                       input logic [31:0] tgt);
    reset               = rst;
    bus.tr              = t;
    bus.stall           = s;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_tr(input bit t, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, t, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    initial_address     = 32'h0000_0100;
    reset               = 1'b1;
    bus.tr              = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);        // reset
    run_tr(1'b0, 5);                             // idle, pc stays 0x100
    run_tr(1'b1, 4);                             // 0x100,0x104 delivered, 0x108 in flight
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);  // stall
    run_tr(1'b1, 2);                             // 0x108, 0x10C; 0x110 in flight
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0203); // redirect discards 0x110
    run_tr(1'b1, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300); // redirect + stall together
    run_tr(1'b1, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0120);
    run_tr(1'b1, 1);                             // 0x120 issued
    run_tr(1'b0, 4);                             // drain to idle
    run_tr(1'b1, 4);                             // resumes at 0x124
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8); // pc wrap
    run_tr(1'b1, 5);
    run_tr(1'b0, 4);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400); // redirect while idle
    run_tr(1'b0, 2);
    run_tr(1'b1, 4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);        // reset mid-run
    run_tr(1'b1, 3);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) initial_address = $urandom;
      drive($urandom_range(99) == 0, $urandom_range(99) < 85,
            $urandom_range(99) < 20, $urandom_range(99) < 10, $urandom);
    end

    run_tr(1'b0, 6);
    check("scoreboard_empty", expq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
